// File: rtl/center_light_pkg.sv
// Shared definitions for the tug-of-war playfield light cells.
package center_light_pkg;

    localparam logic LIGHT_ON  = 1'b1;
    localparam logic LIGHT_OFF = 1'b0;

    // The cell state is one flop. The encoding matches the LED level.
    typedef enum logic {
        ST_OFF = LIGHT_OFF,
        ST_ON  = LIGHT_ON
    } light_state_t;

endpackage

// File: rtl/center_light.sv
// Centre light cell of the tug-of-war game: tracks whether the rope marker
// sits in the middle of the playfield.
//
// L and R are player presses. NL and NR are the lightOn outputs of the
// left and right neighbours.
//
// While ON, a single press moves the marker off the centre. Presses on both
// sides in the same cycle cancel out.
//
// While OFF, the marker comes back only when it is pulled toward the centre:
//   - a right pull with the left neighbour lit, or
//   - a left pull with the right neighbour lit.
//
// lightOn comes straight from the state flop, so no input reaches the output
// in the same cycle.
module center_light
    import center_light_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic L,
    input  logic R,
    input  logic NL,
    input  logic NR,
    output logic lightOn
);

    light_state_t state;
    light_state_t state_next;

    // State register; reset puts the marker back in the centre.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ON;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision from the presses and the neighbour lights.
    always_comb begin
        state_next = state;
        case (state)
            ST_ON: begin
                // Exactly one press pulls the marker off the centre.
                if (L ^ R) begin
                    state_next = ST_OFF;
                end
            end
            ST_OFF: begin
                if ((NL && R && !L) || (NR && L && !R)) begin
                    state_next = ST_ON;
                end
            end
            default: state_next = ST_ON;
        endcase
    end

    assign lightOn = (state == ST_ON) ? LIGHT_ON : LIGHT_OFF;

endmodule

// File: tb/tb_center_light.sv
// Self-checking bench for center_light.
// The driver applies one input vector per cycle and queues the lightOn value
// expected after that edge. The monitor compares lightOn just after every
// rising edge while expectations are pending.
module tb_center_light;

    logic clk;
    logic reset;
    logic L;
    logic R;
    logic NL;
    logic NR;
    logic lightOn;

    logic [0:0]  exp_q[$];
    string       name_q[$];
    int          checks;
    int          failures;

    center_light dut (
        .clk     (clk),
        .reset   (reset),
        .L       (L),
        .R       (R),
        .NL      (NL),
        .NR      (NR),
        .lightOn (lightOn)
    );

    // Clock and reset-time input defaults.
    initial begin
        clk   = 1'b0;
        reset = 1'b0;
        L     = 1'b0;
        R     = 1'b0;
        NL    = 1'b0;
        NR    = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: set inputs on the falling edge and queue the value expected
    // after the next rising edge.
    task automatic apply(input string nm, input logic rst, input logic l,
                         input logic r, input logic nl, input logic nr,
                         input logic exp);
        @(negedge clk);
        reset = rst;
        L     = l;
        R     = r;
        NL    = nl;
        NR    = nr;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // Monitor and scoreboard: lightOn is sampled 1 time unit after each
    // rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [0:0] e;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks = checks + 1;
            if (lightOn !== e) begin
                failures = failures + 1;
                $display("FAIL %s: lightOn=%b expected=%b", n, lightOn, e);
            end
        end
    end

    // Directed stimulus. Arguments are: name, reset, L, R, NL, NR, expected.
    initial begin
        checks   = 0;
        failures = 0;

        // Reset with idle inputs, then stay on.
        apply("reset",          1, 0, 0, 0, 0, 1);
        apply("idle_after_rst", 0, 0, 0, 0, 0, 1);
        apply("idle_after_rst", 0, 0, 0, 0, 0, 1);

        // Right pull moves the marker off; holding R keeps it off.
        apply("right_pull_off", 0, 0, 1, 0, 0, 0);
        apply("right_held_off", 0, 0, 1, 0, 0, 0);

        // Left pull with right neighbour lit brings it back.
        apply("left_pull_back", 0, 1, 0, 0, 1, 1);
        apply("idle_on",        0, 0, 0, 0, 0, 1);

        // A tie while on holds; then a single left press moves it off.
        apply("tie_on_1",       0, 1, 1, 0, 0, 1);
        apply("tie_on_2",       0, 1, 1, 0, 0, 1);
        apply("tie_on_3",       0, 1, 1, 0, 0, 1);
        apply("left_pull_off",  0, 1, 0, 0, 0, 0);

        // A tie while off with a neighbour lit holds; then a right pull
        // from the left neighbour brings it back.
        apply("tie_off_nl",     0, 1, 1, 1, 0, 0);
        apply("tie_off_nr",     0, 1, 1, 0, 1, 0);
        apply("right_pull_nl",  0, 0, 1, 1, 0, 1);

        // Neighbour inputs are ignored while on.
        apply("on_ignores_nb",  0, 0, 0, 1, 1, 1);

        // Pulls away from the centre, or presses with no neighbour lit,
        // keep the light off.
        apply("off_again",      0, 1, 0, 0, 0, 0);
        apply("off_r_no_nb",    0, 0, 1, 0, 0, 0);
        apply("off_l_no_nb",    0, 1, 0, 0, 0, 0);
        apply("off_l_with_nl",  0, 1, 0, 1, 0, 0);
        apply("off_r_with_nr",  0, 0, 1, 0, 1, 0);
        apply("off_idle_nb",    0, 0, 0, 1, 1, 0);

        // Reset overrides a pull back from off, and a pull off from on.
        apply("rst_prio_off",   1, 1, 0, 0, 1, 1);
        apply("rst_prio_on",    1, 0, 1, 0, 0, 1);
        apply("after_rst_pull", 0, 0, 1, 0, 0, 0);

        @(negedge clk);
        reset = 1'b0;
        L     = 1'b0;
        R     = 1'b0;
        NL    = 1'b0;
        NR    = 1'b0;

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
